// File: rtl/rgb_to_hsv_pipe.sv
// Fully pipelined RGB-to-HSV converter: one analysis stage, max(SW,HW) restoring-divider
// stages (one quotient bit each, MSB first) and an output stage; valid/ready with global stall.
module rgb_to_hsv_pipe #(
   parameter int CW   = 4,
   parameter int HW   = 8,
   parameter int SW   = 8,
   parameter int TAGW = 20
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   valid_in,
   output logic                   ready_out,
   input  logic [3*CW-1:0]        rgb_in,
   input  logic [TAGW-1:0]        tag_in,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [HW+SW+CW-1:0]    hsv_out,
   output logic [TAGW-1:0]        tag_out
);
   localparam int QW = (SW > HW) ? SW : HW;
   localparam int NW = QW + CW;
   localparam logic [NW-1:0] S_FULL = NW'((2 ** SW) - 1);
   localparam logic [NW-1:0] SEC    = NW'(((2 ** HW) + 3) / 6);
   localparam logic [HW-1:0] OFF_G  = HW'(((2 ** HW) + 1) / 3);
   localparam logic [HW-1:0] OFF_B  = HW'(((2 ** (HW + 1)) + 1) / 3);

   typedef enum logic [1:0] {DOM_R = 2'd0, DOM_G = 2'd1, DOM_B = 2'd2} dom_e;

   logic                         stall_s;
   logic [CW-1:0]                r_s, g_s, b_s, max_s, min_s, delta_s, dx_s, dy_s, dabs_s;
   logic                         dneg_s;
   dom_e                         dom_s;

   logic [QW:0]                  vld_q, vld_d, zero_q, zero_d, neg_q, neg_d;
   logic [QW:0][TAGW-1:0]        tag_q, tag_d;
   logic [QW:0][CW-1:0]          v_q, v_d;
   logic [QW:0][1:0]             dom_q, dom_d;
   logic [QW:0][QW-1:0]          s_quo_q, s_quo_d, h_quo_q, h_quo_d;
   logic [QW-1:0][NW-1:0]        s_rem_q, s_rem_d, h_rem_q, h_rem_d;
   logic [QW-1:0][CW-1:0]        s_div_q, s_div_d, h_div_q, h_div_d;
   logic [QW-1:0][NW-1:0]        s_sub_s, h_sub_s;
   logic [QW-1:0]                s_ge_s, h_ge_s;

   logic                         vld_out_q, vld_out_d;
   logic [HW+SW+CW-1:0]          hsv_q, hsv_d;
   logic [TAGW-1:0]              tag_out_q, tag_out_d;
   logic [HW-1:0]                h_off_s, h_val_s;
   logic [SW-1:0]                s_val_s;

   assign stall_s   = vld_out_q && !ready_in;
   assign ready_out = !stall_s;
   assign valid_out = vld_out_q;
   assign hsv_out   = hsv_q;
   assign tag_out   = tag_out_q;

   // Analysis: extremes, dominant channel (R > G > B on ties) and |d| with its sign
   always_comb begin
      r_s = rgb_in[3*CW-1:2*CW];
      g_s = rgb_in[2*CW-1:CW];
      b_s = rgb_in[CW-1:0];
      dom_s = DOM_R;
      max_s = r_s;
      dx_s  = g_s;
      dy_s  = b_s;
      if ((r_s >= g_s) && (r_s >= b_s)) begin
         dom_s = DOM_R; max_s = r_s; dx_s = g_s; dy_s = b_s;
      end else if (g_s >= b_s) begin
         dom_s = DOM_G; max_s = g_s; dx_s = b_s; dy_s = r_s;
      end else begin
         dom_s = DOM_B; max_s = b_s; dx_s = r_s; dy_s = g_s;
      end
      min_s   = (r_s < g_s) ? ((r_s < b_s) ? r_s : b_s) : ((g_s < b_s) ? g_s : b_s);
      delta_s = max_s - min_s;
      dneg_s  = (dx_s < dy_s);
      dabs_s  = dneg_s ? (dy_s - dx_s) : (dx_s - dy_s);
   end

   // Restoring-divider trial subtraction for every stage
   always_comb begin
      s_sub_s = '0;
      h_sub_s = '0;
      s_ge_s  = '0;
      h_ge_s  = '0;
      for (int k = 0; k < QW; k++) begin
         s_sub_s[k] = NW'(s_div_q[k]) << (QW - 1 - k);
         h_sub_s[k] = NW'(h_div_q[k]) << (QW - 1 - k);
         s_ge_s[k]  = (s_rem_q[k] >= s_sub_s[k]);
         h_ge_s[k]  = (h_rem_q[k] >= h_sub_s[k]);
      end
   end

   // Next state of every stage; the register block applies it only when not stalled
   always_comb begin
      vld_d   = vld_q;   zero_d  = zero_q;  neg_d   = neg_q;   tag_d   = tag_q;
      v_d     = v_q;     dom_d   = dom_q;   s_quo_d = s_quo_q; h_quo_d = h_quo_q;
      s_rem_d = s_rem_q; h_rem_d = h_rem_q; s_div_d = s_div_q; h_div_d = h_div_q;

      vld_d[0]   = valid_in;
      tag_d[0]   = tag_in;
      v_d[0]     = max_s;
      zero_d[0]  = (delta_s == {CW{1'b0}});
      neg_d[0]   = dneg_s;
      dom_d[0]   = dom_s;
      s_quo_d[0] = '0;
      h_quo_d[0] = '0;
      s_rem_d[0] = S_FULL * NW'(delta_s);
      h_rem_d[0] = SEC * NW'(dabs_s);
      // A zero divisor only occurs with a zero numerator; 1 keeps the quotient at 0
      s_div_d[0] = (max_s == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : max_s;
      h_div_d[0] = (delta_s == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : delta_s;

      for (int k = 1; k <= QW; k++) begin
         vld_d[k]  = vld_q[k-1];
         tag_d[k]  = tag_q[k-1];
         v_d[k]    = v_q[k-1];
         zero_d[k] = zero_q[k-1];
         neg_d[k]  = neg_q[k-1];
         dom_d[k]  = dom_q[k-1];
         s_quo_d[k]         = s_quo_q[k-1];
         s_quo_d[k][QW-k]   = s_ge_s[k-1];
         h_quo_d[k]         = h_quo_q[k-1];
         h_quo_d[k][QW-k]   = h_ge_s[k-1];
      end
      for (int k = 1; k < QW; k++) begin
         s_rem_d[k] = s_ge_s[k-1] ? (s_rem_q[k-1] - s_sub_s[k-1]) : s_rem_q[k-1];
         h_rem_d[k] = h_ge_s[k-1] ? (h_rem_q[k-1] - h_sub_s[k-1]) : h_rem_q[k-1];
         s_div_d[k] = s_div_q[k-1];
         h_div_d[k] = h_div_q[k-1];
      end

      case (dom_q[QW])
         DOM_R:   h_off_s = {HW{1'b0}};
         DOM_G:   h_off_s = OFF_G;
         DOM_B:   h_off_s = OFF_B;
         default: h_off_s = {HW{1'b0}};
      endcase
      // Negative hue offsets wrap modulo 2^HW
      h_val_s = neg_q[QW] ? (h_off_s - h_quo_q[QW][HW-1:0]) : (h_off_s + h_quo_q[QW][HW-1:0]);
      s_val_s = s_quo_q[QW][SW-1:0];
      h_val_s = zero_q[QW] ? {HW{1'b0}} : h_val_s;
      s_val_s = zero_q[QW] ? {SW{1'b0}} : s_val_s;

      vld_out_d = vld_q[QW];
      hsv_d     = {h_val_s, s_val_s, v_q[QW]};
      tag_out_d = tag_q[QW];
   end

   // Pipeline and output registers; everything holds while the output is blocked
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld_q   <= '0; zero_q  <= '0; neg_q   <= '0; tag_q   <= '0;
         v_q     <= '0; dom_q   <= '0; s_quo_q <= '0; h_quo_q <= '0;
         s_rem_q <= '0; h_rem_q <= '0; s_div_q <= '0; h_div_q <= '0;
         vld_out_q <= 1'b0;
         hsv_q     <= '0;
         tag_out_q <= '0;
      end else if (!stall_s) begin
         vld_q   <= vld_d;   zero_q  <= zero_d;  neg_q   <= neg_d;   tag_q   <= tag_d;
         v_q     <= v_d;     dom_q   <= dom_d;   s_quo_q <= s_quo_d; h_quo_q <= h_quo_d;
         s_rem_q <= s_rem_d; h_rem_q <= h_rem_d; s_div_q <= s_div_d; h_div_q <= h_div_d;
         vld_out_q <= vld_out_d;
         hsv_q     <= hsv_d;
         tag_out_q <= tag_out_d;
      end
   end
endmodule

// File: tb/tb_rgb_to_hsv_pipe.sv
// Self-checking bench for rgb_to_hsv_pipe: directed colours, backpressure streaming,
// mid-stream reset and an exhaustive sweep of a CW=5/HW=9/SW=10 instance.
module tb_rgb_to_hsv_pipe;
   localparam int LAT  = 10;
   localparam int LAT2 = 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in, ready_out, valid_out, ready_in;
   logic [11:0] rgb_in;
   logic [19:0] tag_in, tag_out, hsv_out;

   logic        valid2_in, ready2_out, valid2_out, ready2_in;
   logic [14:0] rgb2_in;
   logic [19:0] tag2_in, tag2_out;
   logic [23:0] hsv2_out;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] pix [64];

   always #5 clk = ~clk;

   rgb_to_hsv_pipe dut (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out),
      .rgb_in(rgb_in), .tag_in(tag_in), .valid_out(valid_out), .ready_in(ready_in),
      .hsv_out(hsv_out), .tag_out(tag_out)
   );

   rgb_to_hsv_pipe #(.CW(5), .HW(9), .SW(10), .TAGW(20)) dut2 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid2_in), .ready_out(ready2_out),
      .rgb_in(rgb2_in), .tag_in(tag2_in), .valid_out(valid2_out), .ready_in(ready2_in),
      .hsv_out(hsv2_out), .tag_out(tag2_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference conversion using plain integer division
   function automatic int model_hsv(input int cw, input int hw, input int sw,
                                    input int r, input int g, input int b);
      int mx, mn, dl, d, off, q, h, s;
      mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
      mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
      dl = mx - mn;
      h = 0; s = 0; d = 0; off = 0;
      if (dl != 0) begin
         s = (((2 ** sw) - 1) * dl) / mx;
         if (r >= g && r >= b) begin d = g - b; off = 0; end
         else if (g >= b) begin d = b - r; off = ((2 ** hw) + 1) / 3; end
         else begin d = r - g; off = ((2 ** (hw + 1)) + 1) / 3; end
         q = ((((2 ** hw) + 3) / 6) * ((d < 0) ? -d : d)) / dl;
         h = off + ((d < 0) ? -q : q);
         h = ((h % (2 ** hw)) + (2 ** hw)) % (2 ** hw);
      end
      return (h << (sw + cw)) | (s << cw) | mx;
   endfunction

   task automatic run_single(input string tag, input logic [11:0] rgb, input logic [19:0] tg,
                             input logic [19:0] exp);
      int lat;
      ready_in = 1'b1; valid_in = 1'b1; rgb_in = rgb; tag_in = tg;
      #1;
      check_eq({tag, "_rdy"}, 32'(ready_out), 32'd1);
      step();
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 3 * LAT) begin
         step();
         lat++;
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
      check_eq({tag, "_hsv"}, 32'(hsv_out), 32'(exp));
      check_eq({tag, "_tag"}, 32'(tag_out), 32'(tg));
      step();
      check_eq({tag, "_drain"}, 32'(valid_out), 32'd0);
   endtask

   initial begin
      int lat, tx, rx, cyc, first, rx2;
      rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; rgb_in = 12'd0; tag_in = 20'd0;
      valid2_in = 1'b0; ready2_in = 1'b1; rgb2_in = 15'd0; tag2_in = 20'd0;
      repeat (3) step();
      check_eq("rst_vld", 32'(valid_out), 32'd0);
      check_eq("rst_hsv", 32'(hsv_out), 32'd0);
      check_eq("rst_tag", 32'(tag_out), 32'd0);
      rst_n = 1'b1;
      step();
      check_eq("rst_rdy", 32'(ready_out), 32'd1);

      run_single("red",    12'hF00, 20'h00001, {8'd0,   8'd255, 4'd15});
      run_single("green",  12'h0F0, 20'h00002, {8'd85,  8'd255, 4'd15});
      run_single("blue",   12'h00F, 20'h00003, {8'd171, 8'd255, 4'd15});
      run_single("magent", 12'hF0F, 20'h00004, {8'd213, 8'd255, 4'd15});
      run_single("ff8",    12'hFF8, 20'h00005, {8'd43,  8'd119, 4'd15});
      run_single("f80",    12'hF80, 20'h00006, {8'd22,  8'd255, 4'd15});
      run_single("black",  12'h000, 20'h00007, 20'd0);

      // Grey with output blocked: pipeline must fill, then hold the pixel
      ready_in = 1'b0; valid_in = 1'b1; rgb_in = 12'h888; tag_in = 20'h00777;
      #1;
      check_eq("empty_rdy", 32'(ready_out), 32'd1);
      step();
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 3 * LAT) begin
         step();
         lat++;
      end
      check_eq("grey_lat", 32'(lat), 32'(LAT));
      check_eq("grey_stall_rdy", 32'(ready_out), 32'd0);
      repeat (3) step();
      check_eq("grey_hold_vld", 32'(valid_out), 32'd1);
      check_eq("grey_hsv", 32'(hsv_out), 32'(20'h00008));
      check_eq("grey_tag", 32'(tag_out), 32'(20'h00777));
      ready_in = 1'b1;
      #1;
      check_eq("grey_release_rdy", 32'(ready_out), 32'd1);
      step();
      check_eq("grey_drain", 32'(valid_out), 32'd0);

      // Streaming with random backpressure
      for (int i = 0; i < 64; i++) pix[i] = 12'($urandom_range(0, 4095));
      tx = 0; rx = 0; cyc = 0;
      while (rx < 64 && cyc < 3000) begin
         ready_in = 1'($urandom_range(0, 1));
         valid_in = (tx < 64);
         rgb_in   = pix[(tx < 64) ? tx : 0];
         tag_in   = 20'(tx);
         #1;
         check_eq("strm_rdy", 32'(ready_out), 32'(!(valid_out && !ready_in)));
         if (valid_out && ready_in) begin
            check_eq("strm_tag", 32'(tag_out), 32'(rx));
            check_eq("strm_hsv", 32'(hsv_out),
                     32'(model_hsv(4, 8, 8, int'(pix[rx][11:8]), int'(pix[rx][7:4]), int'(pix[rx][3:0]))));
            rx++;
         end
         if (valid_in && ready_out) tx++;
         step();
         cyc++;
      end
      check_eq("strm_count", 32'(rx), 32'd64);
      valid_in = 1'b0; ready_in = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         check_eq("strm_dup", 32'(valid_out), 32'd0);
      end

      // Reset with five pixels in flight
      for (int i = 0; i < 5; i++) begin
         valid_in = 1'b1; rgb_in = 12'hF00; tag_in = 20'(100 + i);
         step();
      end
      valid_in = 1'b0;
      repeat (LAT - 5) step();
      check_eq("pre_rst_vld", 32'(valid_out), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_vld", 32'(valid_out), 32'd0);
      check_eq("mid_rst_hsv", 32'(hsv_out), 32'd0);
      check_eq("mid_rst_tag", 32'(tag_out), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      run_single("post_rst", 12'h0F0, 20'd200, {8'd85, 8'd255, 4'd15});
      for (int i = 0; i < 15; i++) begin
         step();
         check_eq("post_rst_stale", 32'(valid_out), 32'd0);
      end

      // Exhaustive sweep on the wider instance
      first = -1; rx2 = 0;
      for (int it = 0; it < 32768 + 40 && rx2 < 32768; it++) begin
         valid2_in = (it < 32768);
         rgb2_in   = 15'(it);
         tag2_in   = 20'(it);
         #1;
         if (valid2_out) begin
            if (first < 0) begin
               first = it;
               check_eq("sweep_lat", 32'(it), 32'(LAT2));
            end
            check_eq("sweep_hsv", 32'(hsv2_out),
                     32'(model_hsv(5, 9, 10, (rx2 >> 10) & 31, (rx2 >> 5) & 31, rx2 & 31)));
            check_eq("sweep_tag", 32'(tag2_out), 32'(rx2));
            rx2++;
         end
         step();
      end
      valid2_in = 1'b0;
      check_eq("sweep_count", 32'(rx2), 32'd32768);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
